// File: rtl/pivot_row_div_ctrl.sv
// Pivot-row normalisation controller: streams one tableau row through an external divider
// with a latched pivot factor, writes tagged quotients to BRAM, handles credits, errors, abort.
module pivot_row_div_ctrl #(
   parameter int unsigned DATAW   = 32,
   parameter int unsigned IDXW    = 16,
   parameter int unsigned ADDRW   = 16,
   parameter int unsigned MAX_OUT = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             abort,
   input  logic [IDXW-1:0]  num_cols,
   input  logic [ADDRW-1:0] row_base,
   input  logic [DATAW-1:0] factor_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDXW-1:0]  err_col,
   input  logic [DATAW-1:0] s_row_tdata,
   input  logic             s_row_tvalid,
   output logic             s_row_tready,
   output logic [DATAW-1:0] m_op_a,
   output logic [DATAW-1:0] m_op_b,
   output logic [IDXW-1:0]  m_op_tag,
   output logic             m_op_tvalid,
   input  logic             m_op_tready,
   input  logic [DATAW-1:0] s_res_tdata,
   input  logic [3:0]       s_res_flags,
   input  logic [IDXW-1:0]  s_res_tag,
   input  logic             s_res_tvalid,
   output logic             s_res_tready,
   output logic             wen,
   output logic [ADDRW-1:0] waddr,
   output logic [DATAW-1:0] wdata
);

   localparam int unsigned OUTW = $clog2(MAX_OUT + 1);
   localparam logic [OUTW-1:0] MaxOut = OUTW'(MAX_OUT);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e           state_q;
   logic [IDXW-1:0]  ncols_q, issued_q, received_q, err_col_q;
   logic [ADDRW-1:0] base_q, waddr_q;
   logic [DATAW-1:0] factor_q, wdata_q;
   logic [OUTW-1:0]  outstanding_q, outstanding_d;
   logic             done_q, err_q, wen_q;
   logic             gate, issue, res_acc, res_dec, res_bad;

   assign gate = (state_q == StRun) && (issued_q < ncols_q) && (outstanding_q < MaxOut);
   assign m_op_tvalid  = s_row_tvalid && gate;
   assign s_row_tready = m_op_tready && gate;
   assign issue        = s_row_tvalid && m_op_tready && gate;
   assign m_op_a       = s_row_tdata;
   assign m_op_b       = factor_q;
   assign m_op_tag     = issued_q;
   assign s_res_tready = 1'b1;

   // Results seen in IDLE are swallowed without touching any state.
   assign res_acc = s_res_tvalid && (state_q != StIdle);
   assign res_dec = res_acc && (outstanding_q != '0);
   assign res_bad = |s_res_flags;

   always_comb begin
      outstanding_d = outstanding_q;
      if (issue && !res_dec) begin
         outstanding_d = outstanding_q + OUTW'(1);
      end else if (!issue && res_dec) begin
         outstanding_d = outstanding_q - OUTW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= StIdle;
         ncols_q       <= '0;
         issued_q      <= '0;
         received_q    <= '0;
         err_col_q     <= '0;
         base_q        <= '0;
         waddr_q       <= '0;
         factor_q      <= '0;
         wdata_q       <= '0;
         outstanding_q <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         wen_q         <= 1'b0;
      end else begin
         done_q        <= 1'b0;
         wen_q         <= 1'b0;
         outstanding_q <= outstanding_d;
         if (issue) begin
            issued_q <= issued_q + IDXW'(1);
         end
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  ncols_q       <= num_cols;
                  base_q        <= row_base;
                  factor_q      <= factor_in;
                  issued_q      <= '0;
                  received_q    <= '0;
                  outstanding_q <= '0;
                  err_q         <= 1'b0;
                  err_col_q     <= '0;
                  if (num_cols == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q <= StRun;
                  end
               end
            end
            StRun: begin
               if ((res_acc && res_bad) || abort) begin
                  err_q <= 1'b1;
                  if (res_acc && res_bad) begin
                     err_col_q <= s_res_tag;
                  end
                  // Nothing left in flight: finish now rather than spend a cycle in DRAIN.
                  if (outstanding_d == '0) begin
                     state_q <= StIdle;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StDrain;
                  end
               end else if (res_acc) begin
                  wen_q      <= 1'b1;
                  waddr_q    <= base_q + ADDRW'(s_res_tag);
                  wdata_q    <= s_res_tdata;
                  received_q <= received_q + IDXW'(1);
                  if ((received_q + IDXW'(1)) == ncols_q) begin
                     state_q <= StIdle;
                     done_q  <= 1'b1;
                  end
               end
            end
            StDrain: begin
               if (outstanding_d == '0) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign err     = err_q;
   assign err_col = err_col_q;
   assign wen     = wen_q;
   assign waddr   = waddr_q;
   assign wdata   = wdata_q;

endmodule

// File: tb/tb_pivot_row_div_ctrl.sv
// Self-checking bench for pivot_row_div_ctrl: bench-side divider, job-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_pivot_row_div_ctrl;
   localparam int DW = 32;
   localparam int IW = 16;
   localparam int AW = 16;
   localparam int MO = 4;

   logic clk = 1'b0;
   logic resetn, start, abort;
   logic [IW-1:0] num_cols;
   logic [AW-1:0] row_base;
   logic [DW-1:0] factor_in;
   logic busy, done, err, wen;
   logic [IW-1:0] err_col, m_op_tag, s_res_tag;
   logic [DW-1:0] s_row_tdata, m_op_a, m_op_b, s_res_tdata, wdata;
   logic s_row_tvalid, s_row_tready, m_op_tvalid, m_op_tready, s_res_tvalid, s_res_tready;
   logic [3:0] s_res_flags;
   logic [AW-1:0] waddr;

   pivot_row_div_ctrl #(.DATAW(DW), .IDXW(IW), .ADDRW(AW), .MAX_OUT(MO)) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .num_cols(num_cols),
      .row_base(row_base), .factor_in(factor_in), .busy(busy), .done(done), .err(err),
      .err_col(err_col), .s_row_tdata(s_row_tdata), .s_row_tvalid(s_row_tvalid),
      .s_row_tready(s_row_tready), .m_op_a(m_op_a), .m_op_b(m_op_b), .m_op_tag(m_op_tag),
      .m_op_tvalid(m_op_tvalid), .m_op_tready(m_op_tready), .s_res_tdata(s_res_tdata),
      .s_res_flags(s_res_flags), .s_res_tag(s_res_tag), .s_res_tvalid(s_res_tvalid),
      .s_res_tready(s_res_tready), .wen(wen), .waddr(waddr), .wdata(wdata)
   );

   always #5 clk = ~clk;

   typedef struct {logic [IW-1:0] tag; logic [DW-1:0] data; int due;} op_t;
   op_t pend[$];

   int checks = 0, errors = 0, cyc = 0;
   logic [DW-1:0] row [0:15];
   int row_len, row_idx;
   bit feed_en, res_auto;
   int lat, flag_tag;
   int wcount, issues, issues_err, issues_before_res, late_drop;
   bit first_res_seen;
   logic [AW-1:0] waddr_log[$];
   logic [DW-1:0] mem [int];

   // Reference model: job-level view of what the controller must present after each edge.
   bit m_busy, m_drain, m_done, m_err, m_wen;
   int m_ncols, m_iss, m_rcv, m_inf;
   logic [AW-1:0] m_base, m_waddr;
   logic [DW-1:0] m_factor, m_wdata;
   logic [IW-1:0] m_errcol;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] quot(logic [DW-1:0] a);
      case (a)
         32'h4000_0000: return 32'h3F80_0000;
         32'h4080_0000: return 32'h4000_0000;
         32'h40C0_0000: return 32'h4040_0000;
         32'h4100_0000: return 32'h4080_0000;
         default:       return a ^ 32'h00FF_00FF;
      endcase
   endfunction

   task automatic model_reset();
      m_busy = 0; m_drain = 0; m_done = 0; m_err = 0; m_wen = 0;
      m_ncols = 0; m_iss = 0; m_rcv = 0; m_inf = 0;
      m_base = '0; m_waddr = '0; m_factor = '0; m_wdata = '0; m_errcol = '0;
   endtask

   function automatic bit m_gate();
      return m_busy && !m_drain && (m_iss < m_ncols) && (m_inf < MO);
   endfunction

   task automatic model_step();
      bit iss, res, stop, fin;
      int inf_after;
      if (!resetn) begin
         model_reset();
         return;
      end
      iss = m_gate() && s_row_tvalid && m_op_tready;
      res = s_res_tvalid;
      m_done = 0; m_wen = 0; stop = 0; fin = 0;
      if (!m_busy) begin
         if (start) begin
            m_ncols = int'(num_cols); m_base = row_base; m_factor = factor_in;
            m_iss = 0; m_rcv = 0; m_inf = 0; m_err = 0; m_errcol = '0;
            if (num_cols == 0) m_done = 1;
            else begin m_busy = 1; m_drain = 0; end
         end
      end else begin
         inf_after = m_inf + (iss ? 1 : 0) - (res ? 1 : 0);
         if (iss) m_iss++;
         if (m_drain) fin = (inf_after == 0);
         else if (res && s_res_flags != 0) begin
            m_err = 1; m_errcol = s_res_tag; stop = 1;
         end else if (abort) begin
            m_err = 1; stop = 1;
         end else if (res) begin
            m_wen = 1; m_waddr = AW'(int'(m_base) + int'(s_res_tag)); m_wdata = s_res_tdata;
            m_rcv++;
            fin = (m_rcv == m_ncols);
         end
         if (stop) begin
            if (inf_after == 0) fin = 1;
            else m_drain = 1;
         end
         m_inf = inf_after;
         if (fin) begin m_busy = 0; m_drain = 0; m_done = 1; end
      end
   endtask

   task automatic compare();
      bit g;
      g = m_gate();
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("err_col", err_col, m_errcol);
      chk("wen", wen, m_wen);
      if (m_wen) begin
         chk("waddr", waddr, m_waddr);
         chk("wdata", wdata, m_wdata);
      end
      chk("s_row_tready", s_row_tready, g && m_op_tready);
      chk("m_op_tvalid", m_op_tvalid, g && s_row_tvalid);
      chk("m_op_b", m_op_b, m_factor);
      if (g && s_row_tvalid) chk("m_op_tag", m_op_tag, m_iss);
      if (wen) begin
         wcount++;
         waddr_log.push_back(waddr);
         mem[int'(waddr)] = wdata;
      end
   endtask

   task automatic present(op_t op);
      s_res_tvalid = 1'b1;
      s_res_tdata  = op.data;
      s_res_tag    = op.tag;
      s_res_flags  = (int'(op.tag) == flag_tag) ? 4'b0010 : 4'b0000;
   endtask

   task automatic tick();
      bit pre_issue, pre_row_hs, pre_res, pre_busy;
      logic [IW-1:0] ptag;
      logic [DW-1:0] pa;
      pre_issue  = m_op_tvalid && m_op_tready && resetn;
      pre_row_hs = s_row_tvalid && s_row_tready && resetn;
      pre_res    = s_res_tvalid && resetn;
      pre_busy   = busy;
      ptag = m_op_tag;
      pa   = m_op_a;
      if (pre_issue && err) issues_err++;
      if (pre_res && !first_res_seen) begin
         first_res_seen = 1;
         issues_before_res = issues;
      end
      if (pre_res && !pre_busy) late_drop++;
      @(posedge clk);
      cyc++;
      model_step();
      if (pre_issue) begin
         pend.push_back('{ptag, quot(pa), cyc + lat});
         issues++;
      end
      if (pre_row_hs) row_idx++;
      #1;
      s_row_tvalid = feed_en && (row_idx < row_len);
      s_row_tdata  = (row_idx < row_len) ? row[row_idx] : '0;
      if (res_auto) begin
         s_res_tvalid = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc) present(pend.pop_front());
      end
      @(negedge clk);
      compare();
   endtask

   task automatic start_job(int nc, int base, logic [DW-1:0] fac, int len, bit autom, int l);
      wcount = 0; issues = 0; issues_err = 0; first_res_seen = 0; issues_before_res = -1;
      waddr_log.delete();
      mem.delete();
      row_len = len; row_idx = 0; feed_en = 1; res_auto = autom; lat = l;
      s_row_tvalid = (len > 0);
      s_row_tdata  = row[0];
      num_cols = IW'(nc); row_base = AW'(base); factor_in = fac;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(int limit);
      int n = 0;
      while (!done && n < limit) begin tick(); n++; end
      chk("done_reached", done, 1);
   endtask

   task automatic wait_issues(int k, int limit);
      int n = 0;
      while (issues < k && n < limit) begin tick(); n++; end
      chk("issue_count_reached", issues, k);
   endtask

   task automatic send_res(int tag);
      int k = -1;
      foreach (pend[i]) if (int'(pend[i].tag) == tag) k = i;
      chk("result_pending", (k >= 0), 1);
      if (k < 0) return;
      present(pend[k]);
      pend.delete(k);
      tick();
      s_res_tvalid = 1'b0;
   endtask

   function automatic logic [DW-1:0] memv(int a);
      return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
   endfunction

   initial begin
      resetn = 1'b0; start = 0; abort = 0; num_cols = '0; row_base = '0; factor_in = '0;
      s_row_tdata = '0; s_row_tvalid = 0; m_op_tready = 1; s_res_tdata = '0; s_res_flags = '0;
      s_res_tag = '0; s_res_tvalid = 0;
      row_len = 0; row_idx = 0; feed_en = 0; res_auto = 1; lat = 5; flag_tag = -1;
      late_drop = 0;
      model_reset();
      for (int i = 0; i < 16; i++) row[i] = '0;

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
      chk("rst_wen", wen, 0); chk("rst_err_col", err_col, 0); chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0); chk("rst_m_op_b", m_op_b, 0);
      resetn = 1'b1;
      tick();

      // Basic row {2,4,6,8} / 2.0, in-order latency 5
      row[0] = 32'h4000_0000; row[1] = 32'h4080_0000; row[2] = 32'h40C0_0000;
      row[3] = 32'h4100_0000;
      start_job(4, 'h20, 32'h4000_0000, 4, 1, 5);
      wait_done(100);
      chk("basic_final_wen_with_done", wen, 1);
      chk("basic_busy_low_at_done", busy, 0);
      chk("basic_writes", wcount, 4);
      chk("basic_q0", memv('h20), 32'h3F80_0000);
      chk("basic_q1", memv('h21), 32'h4000_0000);
      chk("basic_q2", memv('h22), 32'h4040_0000);
      chk("basic_q3", memv('h23), 32'h4080_0000);
      chk("basic_err", err, 0);

      // Credit limit: started in the done cycle, results held 20 cycles
      for (int i = 0; i < 10; i++) row[i] = 32'h3F00_0000 + i;
      start_job(10, 'h100, 32'h4000_0000, 10, 1, 20);
      wait_done(600);
      chk("credit_issues_before_first_result", issues_before_res, 4);
      chk("credit_writes", wcount, 10);
      for (int i = 0; i < 10; i++) chk("credit_data", memv('h100 + i), quot(row[i]));

      // Out-of-order return 2,0,3,1
      row[0] = 32'h4000_0000; row[1] = 32'h4080_0000; row[2] = 32'h40C0_0000;
      row[3] = 32'h4100_0000;
      start_job(4, 'h40, 32'h4000_0000, 4, 0, 0);
      wait_issues(4, 50);
      send_res(2); send_res(0); send_res(3);
      chk("ooo_not_done_early", done, 0);
      send_res(1);
      chk("ooo_done", done, 1);
      chk("ooo_writes", wcount, 4);
      if (waddr_log.size() == 4) begin
         chk("ooo_addr0", waddr_log[0], 'h42); chk("ooo_addr1", waddr_log[1], 'h40);
         chk("ooo_addr2", waddr_log[2], 'h43); chk("ooo_addr3", waddr_log[3], 'h41);
      end
      chk("ooo_d2", memv('h42), 32'h4040_0000);
      chk("ooo_d1", memv('h41), 32'h4000_0000);
      tick();

      // Error: factor 0, flagged result on tag 1
      for (int i = 0; i < 6; i++) row[i] = 32'h4000_0000 + (i << 20);
      flag_tag = 1;
      start_job(6, 'h60, 32'h0000_0000, 6, 1, 3);
      wait_done(200);
      flag_tag = -1;
      chk("error_writes", wcount, 1);
      if (waddr_log.size() > 0) chk("error_waddr", waddr_log[0], 'h60);
      chk("error_data", memv('h60), quot(row[0]));
      chk("error_err", err, 1);
      chk("error_err_col", err_col, 1);
      chk("error_no_issue_after_err", issues_err, 0);
      tick();

      // Abort after 3 issues and 2 results
      row[0] = 32'h4000_0000; row[1] = 32'h4080_0000; row[2] = 32'h40C0_0000;
      start_job(8, 'h80, 32'h4000_0000, 3, 0, 0);
      wait_issues(3, 50);
      send_res(0); send_res(1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_still_busy", busy, 1);
      send_res(2);
      chk("abort_done", done, 1);
      chk("abort_no_final_write", wen, 0);
      chk("abort_writes", wcount, 2);
      chk("abort_err", err, 1);
      chk("abort_err_col", err_col, 0);
      tick();

      // num_cols = 0
      start_job(0, 'h10, 32'h4000_0000, 0, 1, 1);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      tick();
      chk("zero_done_pulse", done, 0);
      chk("zero_writes", wcount, 0);

      // Asynchronous reset mid-RUN, late results dropped in IDLE
      row[0] = 32'h4000_0000; row[1] = 32'h4080_0000; row[2] = 32'h40C0_0000;
      row[3] = 32'h4100_0000;
      start_job(4, 'hA0, 32'h4000_0000, 4, 1, 6);
      wait_issues(2, 20);
      resetn = 1'b0;
      feed_en = 0;
      s_row_tvalid = 1'b0;
      #1;
      chk("arst_busy", busy, 0); chk("arst_err", err, 0); chk("arst_wen", wen, 0);
      chk("arst_m_op_b", m_op_b, 0); chk("arst_tready", s_row_tready, 0);
      model_reset();
      tick();
      resetn = 1'b1;
      late_drop = 0;
      for (int n = 0; n < 30 && (pend.size() > 0 || s_res_tvalid); n++) tick();
      tick();
      chk("arst_late_result_seen", (late_drop > 0), 1);
      chk("arst_no_writes", wcount, 0);
      chk("arst_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pivot_row_div_ctrl.md
# pivot_row_div_ctrl

Parametrised controller for the pivot-row normalisation stage of the LP solver. It streams one tableau row per job to an external floating-point divider, paired with a latched pivot factor and tagged with the column index. It writes each quotient to BRAM at `row_base + tag`, so out-of-order results are tolerated. It adds start/done job control, an outstanding-operation limit, an error drain with error-column capture, and abort.

## Interface
Parameters:
- DATAW, 32, element width (single precision)
- IDXW, 16, column index/tag width
- ADDRW, 16, BRAM word-address width
- MAX_OUT, 16, max divider operations in flight (1..2^IDXW-1)

Ports:
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  reset, asynchronous and active-low
- start  in  1  job request; sampled only in IDLE
- abort  in  1  stop issuing, drain, finish with err
- num_cols  in  IDXW  row length; latched on start
- row_base  in  ADDRW  BRAM base word address; latched on start
- factor_in  in  DATAW  pivot element; latched on start
- busy  out  1  state != IDLE
- done  out  1  one-cycle job-complete pulse
- err  out  1  sticky job error; cleared on next accepted start
- err_col  out  IDXW  tag of first flagged result (0 if abort-only)
- s_row_tdata  in  DATAW  row element
- s_row_tvalid  in  1 / s_row_tready  out  1
- m_op_a  out  DATAW  = s_row_tdata (combinational)
- m_op_b  out  DATAW  latched factor
- m_op_tag  out  IDXW  issue counter
- m_op_tvalid  out  1 / m_op_tready  in  1
- s_res_tdata  in  DATAW  quotient
- s_res_flags  in  4  divider exception bits (any set = error)
- s_res_tag  in  IDXW  returned tag
- s_res_tvalid  in  1 / s_res_tready  out  1, constant 1
- wen  out  1, waddr  out  ADDRW, wdata  out  DATAW  registered BRAM write port

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE→RUN on start. Latch num_cols, row_base, factor. Clear issued, received and err. Exception: num_cols==0 stays in IDLE and pulses done next cycle with no writes.
- Issue gate: state==RUN && issued<num_cols && outstanding<MAX_OUT.
  - m_op_tvalid = s_row_tvalid && gate.
  - s_row_tready = m_op_tready && gate.
  - issued increments on handshake.
- outstanding: +1 on issue and −1 on accepted result; unchanged if both occur in the same cycle. Never exceeds MAX_OUT.
- Results are accepted in RUN and DRAIN.
  - Flags==0 and no error/abort yet: register write with waddr = row_base + s_res_tag (mod 2^ADDRW), wdata = s_res_tdata. received increments.
  - Any flag set: err←1. err_col←tag only on the first error. No write. Go to DRAIN.
  - In DRAIN, results are counted down from outstanding and never written.
- abort in RUN: err←1, go to DRAIN. abort is ignored in IDLE and DRAIN.
- RUN completes when received==num_cols: go to IDLE and pulse done.
- DRAIN completes when outstanding==0, including the cycle of the last result: go to IDLE and pulse done.
- Results arriving in IDLE are accepted and dropped. No write, no state change.
- Width rule: the counters are IDXW wide. outstanding is clog2(MAX_OUT+1) wide.

## Timing
- Reset values: state IDLE; busy, done, err, wen all 0; err_col, waddr, wdata 0; all counters 0; m_op_b 0.
- Issue path is combinational: zero added latency from s_row to m_op.
- Write latency: a result accepted at cycle t produces wen/waddr/wdata at t+1.
- done: the final result accepted at t gives done=1 at t+1, coincident with the final wen, and busy=0 at t+1. A new start is accepted at t+1.
- start is accepted at t: busy=1 from t+1, and the first issue can occur at t+1.
- When issue and error occur in the same cycle, the issue completes and is counted in outstanding.
- Asynchronous reset mid-job clears everything immediately. Pending divider results then arrive in IDLE and are dropped.

## Test plan
- Basic row: num_cols=4, row_base=0x20, factor=2.0, row {2,4,6,8}, in-order divider with latency 5. Required: writes 0x20..0x23 = {1,2,3,4}; done one cycle after the last result; err=0.
- Credit limit: MAX_OUT=4, m_op_tready=1, results held for 20 cycles, num_cols=10. Required: exactly 4 issues, then s_row_tready=0 until the first result; all 10 writes occur.
- Out-of-order: divider returns tags 2,0,3,1. Required: waddr = base+2, base, base+3, base+1 with matching data; done after the 4th result.
- Error: factor=0.0, num_cols=6, flags set on tag 1. Required: only the tag-0 write occurs; err=1, err_col=1; no issues after entering DRAIN; done when outstanding reaches 0.
- Abort: assert abort after 3 issues with 2 results returned, num_cols=8. Required: 2 writes; err=1, err_col=0; done after the 3rd result with no write.
- Edge cases: num_cols=0 gives a done pulse with no writes; async reset mid-RUN gives all outputs 0 and a late result in IDLE is dropped.
